// File: rtl/sga_pkg.sv
// Shared types for the snake body engine: direction codes, FSM states,
// and position field helpers.
package sga_pkg;

  localparam logic [1:0] DIR_XP = 2'b00;
  localparam logic [1:0] DIR_YP = 2'b01;
  localparam logic [1:0] DIR_XN = 2'b10;
  localparam logic [1:0] DIR_YN = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    EVAL,
    SCAN,
    COMMIT,
    HALT
  } state_t;

  function automatic logic [15:0] fld(
    input logic [15:0] pos,
    input int          lsb,
    input int          bits
  );
    return (pos >> lsb) & ((16'd1 << bits) - 16'd1);
  endfunction

endpackage

// File: rtl/snake_body_engine_if.sv
// Control/render bundle for snake_body_engine.
// Optional apple-check signals exist only with SGA_APPLE_CHECK_EN.
interface snake_body_engine_if #(
  parameter int X_BITS  = 3,
  parameter int Y_BITS  = 3,
  parameter int MAX_LEN = 16
);
  localparam int P  = X_BITS + Y_BITS;
  localparam int LB = $clog2(MAX_LEN) + 1;

  logic          start_game;
  logic [P-1:0]  init_pos;
  logic          step;
  logic [1:0]    direction;
  logic          wall_mode;
  logic [P-1:0]  apple_pos;
  logic          apple_valid;
  logic          busy;
  logic          done;
  logic          ate_apple;
  logic          self_collision;
  logic          wall_collision;
  logic          win;
  logic [LB-1:0] length;
  logic [P-1:0]  head;
  logic [LB-2:0] rd_idx;
  logic [P-1:0]  rd_pos;
`ifdef SGA_APPLE_CHECK_EN
  logic          check_req;
  logic [P-1:0]  check_pos;
  logic          check_done;
  logic          in_body;
`endif

  modport master (
    output start_game, init_pos, step, direction,
    output wall_mode, apple_pos, apple_valid, rd_idx,
`ifdef SGA_APPLE_CHECK_EN
    output check_req, check_pos,
    input  check_done, in_body,
`endif
    input  busy, done, ate_apple, self_collision,
    input  wall_collision, win, length, head, rd_pos
  );

  modport slave (
    input  start_game, init_pos, step, direction,
    input  wall_mode, apple_pos, apple_valid, rd_idx,
`ifdef SGA_APPLE_CHECK_EN
    input  check_req, check_pos,
    output check_done, in_body,
`endif
    output busy, done, ate_apple, self_collision,
    output wall_collision, win, length, head, rd_pos
  );

endinterface

// File: rtl/sga_pos_ram.sv
// Circular position buffer: one sync write/read port for the FSM,
// one sync read port for the renderer.
module sga_pos_ram #(
  parameter int P  = 6,
  parameter int AW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [P-1:0]  wdata,
  output logic [P-1:0]  rdata,
  input  logic [AW-1:0] raddr_b,
  output logic [P-1:0]  rdata_b
);

  logic [P-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata   <= '0;
      rdata_b <= '0;
    end else begin
      rdata   <= mem[addr];
      rdata_b <= mem[raddr_b];
    end
  end

endmodule

// File: rtl/snake_body_engine.sv
// Snake body engine: next-head, wall/self/apple checks, scan FSM.
// Define SGA_APPLE_CHECK_EN to add the apple-in-body check port.
module snake_body_engine
  import sga_pkg::*;
#(
  parameter int X_BITS  = 3,
  parameter int Y_BITS  = 3,
  parameter int MAX_LEN = 16
) (
  input logic               clock,
  input logic               reset,
  snake_body_engine_if.slave bus
);

  localparam int P  = X_BITS + Y_BITS;
  localparam int LB = $clog2(MAX_LEN) + 1;
  localparam int AW = LB - 1;

  state_t        state;
  logic [AW-1:0] head_ptr;
  logic [LB-1:0] length;
  logic [LB-1:0] scan_k;
  logic [LB-1:0] scan_n;
  logic [P-1:0]  head_r;
  logic [P-1:0]  target;
  logic          eat;
  logic          done_r;
  logic          ate_r;
  logic          self_r;
  logic          wall_r;
  logic          win_r;
`ifdef SGA_APPLE_CHECK_EN
  logic          chk;
  logic          chk_done_r;
  logic          in_body_r;
`endif

  logic [X_BITS-1:0] hx, nx;
  logic [Y_BITS-1:0] hy, ny;
  logic              hit_wall;
  logic [P-1:0]      nh;
  logic              eat_c;
  logic [LB-1:0]     scan_l;

  always_comb begin
    hx = X_BITS'(fld(16'(head_r), 0, X_BITS));
    hy = Y_BITS'(fld(16'(head_r), X_BITS, Y_BITS));
    nx = hx;
    ny = hy;
    hit_wall = 1'b0;
    unique case (bus.direction)
      DIR_XP: begin nx = hx + 1'b1; hit_wall = &hx;  end
      DIR_XN: begin nx = hx - 1'b1; hit_wall = ~|hx; end
      DIR_YP: begin ny = hy + 1'b1; hit_wall = &hy;  end
      DIR_YN: begin ny = hy - 1'b1; hit_wall = ~|hy; end
    endcase
    hit_wall = hit_wall & bus.wall_mode;
    nh = {ny, nx};
    eat_c = bus.apple_valid && (nh == bus.apple_pos);
    // the tail vacates unless we grow, so it is not an obstacle
    scan_l = eat_c ? length : length - 1'b1;
  end

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [AW-1:0] ram_off;
  logic [P-1:0]  ram_wd;
  logic [P-1:0]  ram_q;

  always_comb begin
    ram_off  = (state == SCAN) ? AW'(scan_k + 1'b1) : '0;
    ram_we   = 1'b0;
    ram_addr = head_ptr + ram_off;
    ram_wd   = target;
    if (reset) begin
      ram_we   = 1'b1;
      ram_addr = '0;
      ram_wd   = '0;
    end else if (bus.start_game) begin
      ram_we   = 1'b1;
      ram_addr = '0;
      ram_wd   = bus.init_pos;
    end else if (state == COMMIT) begin
      ram_we   = 1'b1;
      ram_addr = head_ptr - 1'b1;
    end
  end

  sga_pos_ram #(
    .P (P),
    .AW(AW)
  ) u_ram (
    .clock  (clock),
    .reset  (reset),
    .we     (ram_we),
    .addr   (ram_addr),
    .wdata  (ram_wd),
    .rdata  (ram_q),
    .raddr_b(head_ptr + bus.rd_idx),
    .rdata_b(bus.rd_pos)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      head_ptr <= '0;
      length   <= LB'(1);
      scan_k   <= '0;
      scan_n   <= '0;
      head_r   <= '0;
      target   <= '0;
      eat      <= 1'b0;
      done_r   <= 1'b0;
      ate_r    <= 1'b0;
      self_r   <= 1'b0;
      wall_r   <= 1'b0;
      win_r    <= 1'b0;
`ifdef SGA_APPLE_CHECK_EN
      chk        <= 1'b0;
      chk_done_r <= 1'b0;
      in_body_r  <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      ate_r  <= 1'b0;
`ifdef SGA_APPLE_CHECK_EN
      chk_done_r <= 1'b0;
`endif
      if (bus.start_game) begin
        state    <= IDLE;
        head_ptr <= '0;
        length   <= LB'(1);
        head_r   <= bus.init_pos;
        self_r   <= 1'b0;
        wall_r   <= 1'b0;
        win_r    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.step) begin
              state <= EVAL;
`ifdef SGA_APPLE_CHECK_EN
              chk   <= 1'b0;
            end else if (bus.check_req) begin
              state     <= SCAN;
              target    <= bus.check_pos;
              scan_n    <= length;
              scan_k    <= '0;
              chk       <= 1'b1;
              in_body_r <= 1'b0;
`endif
            end
          end
          EVAL: begin
            target <= nh;
            eat    <= eat_c;
            scan_k <= '0;
            scan_n <= scan_l;
            if (hit_wall) begin
              wall_r <= 1'b1;
              done_r <= 1'b1;
              state  <= HALT;
            end else if (scan_l == '0) begin
              state <= COMMIT;
            end else begin
              state <= SCAN;
            end
          end
          SCAN: begin
            if (ram_q == target) begin
`ifdef SGA_APPLE_CHECK_EN
              if (chk) begin
                in_body_r  <= 1'b1;
                chk_done_r <= 1'b1;
                state      <= IDLE;
              end else
`endif
              begin
                self_r <= 1'b1;
                done_r <= 1'b1;
                state  <= HALT;
              end
            end else if (scan_k == scan_n - 1'b1) begin
`ifdef SGA_APPLE_CHECK_EN
              if (chk) begin
                chk_done_r <= 1'b1;
                state      <= IDLE;
              end else
`endif
              state <= COMMIT;
            end else begin
              scan_k <= scan_k + 1'b1;
            end
          end
          COMMIT: begin
            head_ptr <= head_ptr - 1'b1;
            head_r   <= target;
            done_r   <= 1'b1;
            state    <= IDLE;
            if (eat) begin
              length <= length + 1'b1;
              ate_r  <= 1'b1;
              if (length + 1'b1 == LB'(MAX_LEN)) begin
                win_r <= 1'b1;
                state <= HALT;
              end
            end
          end
          HALT: state <= HALT;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy           = !(state == IDLE || state == HALT);
  assign bus.done           = done_r;
  assign bus.ate_apple      = ate_r;
  assign bus.self_collision = self_r;
  assign bus.wall_collision = wall_r;
  assign bus.win            = win_r;
  assign bus.length         = length;
  assign bus.head           = head_r;
`ifdef SGA_APPLE_CHECK_EN
  assign bus.check_done     = chk_done_r;
  assign bus.in_body        = in_body_r;
`endif

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine on an 8x8 grid, MAX_LEN=8.
module tb_snake_body_engine;

  localparam int XB = 3;
  localparam int YB = 3;
  localparam int ML = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat;
  logic ate_s;
  logic seen;

  snake_body_engine_if #(.X_BITS(XB), .Y_BITS(YB), .MAX_LEN(ML)) bus();

  snake_body_engine #(
    .X_BITS (XB),
    .Y_BITS (YB),
    .MAX_LEN(ML)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Raise step for `hold` cycles; lat counts edges until done (40 = none).
  task automatic move(input logic [1:0] d, input int hold,
                      output int lat_o, output logic ate_o);
    bus.direction = d;
    bus.step = 1'b1;
    lat_o = 0;
    ate_o = 1'b0;
    while (lat_o < 40) begin
      tick();
      lat_o++;
      if (lat_o >= hold) bus.step = 1'b0;
      if (bus.done) begin
        ate_o = bus.ate_apple;
        break;
      end
    end
    bus.step = 1'b0;
  endtask

  task automatic new_game(input logic [5:0] p);
    bus.init_pos = p;
    bus.start_game = 1'b1;
    tick();
    bus.start_game = 1'b0;
  endtask

  task automatic eat_to(input logic [5:0] a, input logic [1:0] d);
    bus.apple_pos = a;
    bus.apple_valid = 1'b1;
    move(d, 1, lat, ate_s);
    bus.apple_valid = 1'b0;
  endtask

`ifdef SGA_APPLE_CHECK_EN
  task automatic body_check(input logic [5:0] p, output int lat_o);
    bus.check_pos = p;
    bus.check_req = 1'b1;
    lat_o = 0;
    while (lat_o < 40) begin
      tick();
      lat_o++;
      bus.check_req = 1'b0;
      if (bus.check_done) break;
    end
    bus.check_req = 1'b0;
  endtask
`endif

  initial begin
    bus.start_game  = 1'b0;
    bus.init_pos    = '0;
    bus.step        = 1'b0;
    bus.direction   = 2'b00;
    bus.wall_mode   = 1'b1;
    bus.apple_pos   = '0;
    bus.apple_valid = 1'b0;
    bus.rd_idx      = '0;
`ifdef SGA_APPLE_CHECK_EN
    bus.check_req   = 1'b0;
    bus.check_pos   = '0;
`endif
    repeat (2) tick();
    check("rst_length", bus.length, 1);
    check("rst_head", bus.head, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_flags", {bus.self_collision, bus.wall_collision, bus.win}, 0);
    check("rst_rd_pos", bus.rd_pos, 0);
    reset = 1'b0;
    tick();

    // plain move, L=0
    new_game(6'o33);
    move(2'b00, 1, lat, ate_s);
    check("mv_lat", lat, 3);
    check("mv_head", bus.head, 6'o34);
    check("mv_len", bus.length, 1);
    check("mv_ate", ate_s, 0);

    // eat one apple
    new_game(6'o33);
    eat_to(6'o34, 2'b00);
    check("eat_lat", lat, 4);
    check("eat_ate", ate_s, 1);
    check("eat_len", bus.length, 2);
    bus.rd_idx = 3'd1;
    tick();
    check("eat_rd1", bus.rd_pos, 6'o33);
    bus.rd_idx = 3'd0;
    tick();
    check("eat_rd0", bus.rd_pos, 6'o34);

    // wall hit and wrap
    new_game(6'o37);
    move(2'b00, 1, lat, ate_s);
    check("wall_lat", lat, 2);
    check("wall_flag", bus.wall_collision, 1);
    check("wall_busy", bus.busy, 0);
    move(2'b00, 1, lat, ate_s);
    check("halt_nodone", lat, 40);
    check("halt_head", bus.head, 6'o37);
    new_game(6'o37);
    check("wall_clr", bus.wall_collision, 0);
    bus.wall_mode = 1'b0;
    move(2'b00, 1, lat, ate_s);
    check("wrap_lat", lat, 3);
    check("wrap_head", bus.head, 6'o30);
    check("wrap_flag", bus.wall_collision, 0);
    bus.wall_mode = 1'b1;

    // reversal into neck, length 3
    new_game(6'o31);
    eat_to(6'o32, 2'b00);
    eat_to(6'o33, 2'b00);
    check("rev3_len0", bus.length, 3);
    move(2'b10, 1, lat, ate_s);
    check("rev3_lat", lat, 4);
    check("rev3_self", bus.self_collision, 1);
    check("rev3_head", bus.head, 6'o33);
    check("rev3_busy", bus.busy, 0);

    // reversal with length 2 is legal
    new_game(6'o32);
    check("self_clr", bus.self_collision, 0);
    eat_to(6'o33, 2'b00);
    move(2'b10, 1, lat, ate_s);
    check("rev2_lat", lat, 4);
    check("rev2_self", bus.self_collision, 0);
    check("rev2_head", bus.head, 6'o32);
    check("rev2_len", bus.length, 2);

    // grow to MAX_LEN
    new_game(6'o30);
    for (int i = 1; i < 8; i++) begin
      eat_to(6'o30 + 6'(i), 2'b00);
    end
    check("win_lat", lat, 10);
    check("win_ate", ate_s, 1);
    check("win_flag", bus.win, 1);
    check("win_len", bus.length, 8);
    check("win_busy", bus.busy, 0);
    bus.rd_idx = 3'd7;
    tick();
    check("win_tail", bus.rd_pos, 6'o30);
    bus.rd_idx = 3'd0;
    move(2'b01, 1, lat, ate_s);
    check("win_halt", lat, 40);
    new_game(6'o30);
    check("restart_len", bus.length, 1);
    check("restart_win", bus.win, 0);
    check("restart_busy", bus.busy, 0);

    // start_game beats step in the same cycle
    bus.init_pos = 6'o22;
    bus.start_game = 1'b1;
    bus.step = 1'b1;
    tick();
    bus.start_game = 1'b0;
    bus.step = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
    check("sg_step_done", seen, 0);
    check("sg_step_head", bus.head, 6'o22);
    check("sg_step_busy", bus.busy, 0);

    // step held through EVAL/SCAN is not queued
    new_game(6'o30);
    eat_to(6'o31, 2'b00);
    eat_to(6'o32, 2'b00);
    eat_to(6'o33, 2'b00);
    move(2'b00, 3, lat, ate_s);
    check("busy_lat", lat, 6);
    check("busy_head", bus.head, 6'o34);
    check("busy_len", bus.length, 4);
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
    check("busy_noqueue", seen, 0);
    check("busy_head2", bus.head, 6'o34);

`ifdef SGA_APPLE_CHECK_EN
    body_check(6'o31, lat);
    check("chk_tail_lat", lat, 5);
    check("chk_tail_in", bus.in_body, 1);
    body_check(6'o55, lat);
    check("chk_free_lat", lat, 5);
    check("chk_free_in", bus.in_body, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
